// File: rtl/pru_cmd_sequencer_if.sv
// pru_cmd_sequencer_if: CPU MMIO bus plus PRU draw handshake bundle.
// slave = sequencer side (mem_*, pru_done in), master = CPU/PRU side.
interface pru_cmd_sequencer_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic [1:0]  pru_color;
  logic [9:0]  pru_col;
  logic [8:0]  pru_row;
  logic [9:0]  pru_width;
  logic [8:0]  pru_hr;
  logic [1:0]  pru_shape;
  logic        pru_start;
  logic        pru_done;
  logic [6:0]  q_count;
`ifdef PRU_SEQ_IRQ_EN
  logic        irq;
`endif

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    input  pru_done,
`ifdef PRU_SEQ_IRQ_EN
    output irq,
`endif
    output mem_rdata,
    output pru_color,
    output pru_col,
    output pru_row,
    output pru_width,
    output pru_hr,
    output pru_shape,
    output pru_start,
    output q_count
  );

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    output pru_done,
`ifdef PRU_SEQ_IRQ_EN
    input  irq,
`endif
    input  mem_rdata,
    input  pru_color,
    input  pru_col,
    input  pru_row,
    input  pru_width,
    input  pru_hr,
    input  pru_shape,
    input  pru_start,
    input  q_count
  );
endinterface

// File: rtl/pru_cmd_sequencer.sv
// pru_cmd_sequencer: MMIO command FIFO issuing draws on the PRU start/done handshake.
// Ports: clk, rst (async, active high), bus (slave modport: mem_* MMIO,
// pru_* draw outputs, pru_done, q_count; irq when PRU_SEQ_IRQ_EN is defined).
module pru_cmd_sequencer #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h4010
) (
  input logic                clk,
  input logic                rst,
  pru_cmd_sequencer_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0] FULL_CNT = 7'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [6:0]    count_q, count_d;
  logic [22:0]   stage_q, stage_d;
  logic [41:0]   out_q, out_d;
  logic          start_q, start_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [41:0]   mem_q [DEPTH];

  logic          wr_lo, wr_hi, wr_st;
  logic          full, empty, pop;
  logic          push_ok, ovf_set, irq_bit;
  logic [41:0]   push_data, head;
  logic [31:0]   status;
  logic          unused_wdata;

  assign unused_wdata = ^bus.mem_wdata[31:23];

  assign wr_lo = bus.mem_we && (bus.mem_addr == BASE_ADDR);
  assign wr_hi = bus.mem_we && (bus.mem_addr == BASE_ADDR + 32'd4);
  assign wr_st = bus.mem_we && (bus.mem_addr == BASE_ADDR + 32'd8);

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == 7'd0);

  // Never pop while the PRU still holds done, so start cannot rise into it.
  assign pop = (state_q == S_IDLE) && !empty && !bus.pru_done;

  // A same-cycle pop frees the slot the push needs.
  assign push_ok = wr_hi && (!full || pop);
  assign ovf_set = wr_hi && !push_ok;

  // Entry layout: {shape, color, row, col, width, hr}.
  assign push_data = {stage_q, bus.mem_wdata[9:0], bus.mem_wdata[18:10]};
  assign head      = mem_q[rd_ptr_q];

  assign status = {16'd0, irq_bit, ovf_q, full, empty,
                   (state_q != S_IDLE), 4'd0, count_q};

  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    stage_d  = wr_lo ? bus.mem_wdata[22:0] : stage_q;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    out_d    = pop ? head : out_q;
    count_d  = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 7'd1;
      2'b01:   count_d = count_q - 7'd1;
      default: count_d = count_q;
    endcase
    // A new overflow wins over a clear in the same cycle.
    ovf_d = ovf_set ? 1'b1 : (wr_st ? 1'b0 : ovf_q);
    unique case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        start_d = !bus.pru_done;
        if (bus.pru_done) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!bus.pru_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rdata_d = bus.mem_re ? status : 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 7'd0;
      stage_q  <= 23'd0;
      out_q    <= 42'd0;
      start_q  <= 1'b0;
      ovf_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stage_q  <= stage_d;
      out_q    <= out_d;
      start_q  <= start_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

`ifdef PRU_SEQ_IRQ_EN
  logic irq_q, irq_d, drained;

  // Last command finished (RELEASE->IDLE) with nothing left or arriving.
  assign drained = (state_q == S_RELEASE) && !bus.pru_done
                   && empty && !push_ok;

  always_comb begin
    irq_d = irq_q;
    if (wr_st)   irq_d = 1'b0;
    if (drained) irq_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq_bit = irq_q;
  assign bus.irq = irq_q;
`else
  assign irq_bit = 1'b0;
`endif

  assign bus.pru_shape = out_q[41:40];
  assign bus.pru_color = out_q[39:38];
  assign bus.pru_row   = out_q[37:29];
  assign bus.pru_col   = out_q[28:19];
  assign bus.pru_width = out_q[18:9];
  assign bus.pru_hr    = out_q[8:0];
  assign bus.pru_start = start_q;
  assign bus.q_count   = count_q;
  assign bus.mem_rdata = rdata_q;
endmodule

// File: tb/tb_pru_cmd_sequencer.sv
// tb_pru_cmd_sequencer: randomized bench for pru_cmd_sequencer with a PRU
// model, an in-order expected-command queue and per-scenario checks.
module tb_pru_cmd_sequencer;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h4010;
  localparam logic [31:0] A_LO  = BASE;
  localparam logic [31:0] A_HI  = BASE + 32'd4;
  localparam logic [31:0] A_ST  = BASE + 32'd8;
  localparam logic [31:0] NO15  = 32'hFFFF_7FFF;

  typedef struct packed {
    logic [1:0] shape;
    logic [1:0] color;
    logic [8:0] row;
    logic [9:0] col;
    logic [9:0] width;
    logic [8:0] hr;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  pru_cmd_sequencer_if bus();

  pru_cmd_sequencer #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // PRU model: done rises pru_lat cycles into start, falls once start drops.
  int pru_lat = 20;
  bit pru_hold = 1'b0;
  int pru_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pru_done <= 1'b0;
      pru_cnt <= 0;
    end else if (bus.pru_start && !bus.pru_done) begin
      if (pru_cnt >= pru_lat - 1 && !pru_hold) bus.pru_done <= 1'b1;
      pru_cnt <= pru_cnt + 1;
    end else if (!bus.pru_start) begin
      bus.pru_done <= 1'b0;
      pru_cnt <= 0;
    end
  end

  // Observation: what the PRU is handed on each start rise.
  cmd_t issued[$];
  cmd_t exp_q[$];
  cmd_t held;
  logic start_prev = 1'b0;
  int   start_while_done = 0;
  int   unstable = 0;

  function automatic cmd_t cur_out();
    return {bus.pru_shape, bus.pru_color, bus.pru_row,
            bus.pru_col, bus.pru_width, bus.pru_hr};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      start_prev = 1'b0;
    end else begin
      if (bus.pru_start && !start_prev) begin
        issued.push_back(cur_out());
        held = cur_out();
        if (bus.pru_done) start_while_done++;
      end else if (bus.pru_start && cur_out() !== held) begin
        unstable++;
      end
      start_prev = bus.pru_start;
    end
  end

  function automatic cmd_t rand_cmd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return cmd_t'(r[41:0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_lo(input cmd_t c);
    logic [31:0] junk;
    junk = $urandom();
    bus.mem_we    = 1'b1;
    bus.mem_addr  = A_LO;
    bus.mem_wdata = {junk[31:23], c.shape, c.color, c.row, c.col};
    tick();
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
  endtask

  task automatic push_hi(input cmd_t c);
    logic [31:0] junk;
    junk = $urandom();
    bus.mem_we    = 1'b1;
    bus.mem_addr  = A_HI;
    bus.mem_wdata = {junk[31:19], c.hr, c.width};
    tick();
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
  endtask

  task automatic push_cmd(input cmd_t c);
    write_lo(c);
    push_hi(c);
  endtask

  task automatic read_status(output logic [31:0] v);
    bus.mem_re   = 1'b1;
    bus.mem_addr = A_ST;
    tick();
    v = bus.mem_rdata;
    bus.mem_re   = 1'b0;
    bus.mem_addr = 32'h0;
  endtask

  task automatic write_status();
    bus.mem_we    = 1'b1;
    bus.mem_addr  = A_ST;
    bus.mem_wdata = $urandom();
    tick();
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
  endtask

  task automatic wait_issued(input int n);
    for (int i = 0; i < 3000 && issued.size() < n; i++) tick();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (!bus.pru_start && !bus.pru_done && bus.q_count == 7'd0
          && issued.size() >= exp_q.size()) break;
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] st;
    bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
    bus.mem_we = 1'b0; bus.mem_re = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.q_count !== 7'd0) begin
      n_fail++; $display("FAIL reset_qcount got %0d exp 0", bus.q_count);
    end
    n_checks++;
    if (bus.pru_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_start got %b exp 0", bus.pru_start);
    end
    n_checks++;
    if (cur_out() !== 42'd0) begin
      n_fail++; $display("FAIL reset_outputs got %h exp 0", cur_out());
    end
    n_checks++;
    if (bus.mem_rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_rdata got %h exp 0", bus.mem_rdata);
    end
    read_status(st);
    n_checks++;
    if (st !== 32'h0000_1000) begin
      n_fail++; $display("FAIL reset_status got %h exp 00001000", st);
    end
    tick();
    n_checks++;
    if (bus.mem_rdata !== 32'd0) begin
      n_fail++; $display("FAIL rdata_idle got %h exp 0", bus.mem_rdata);
    end
  endtask

  task automatic test_single();
    cmd_t c;
    int hi;
    c = '{shape: 2'd0, color: 2'd2, row: 9'd7, col: 10'd5,
          width: 10'd10, hr: 9'd4};
    pru_lat = 20;
    pru_hold = 1'b0;
    push_cmd(c);
    n_checks++;
    if (bus.q_count !== 7'd1) begin
      n_fail++; $display("FAIL single_qcount_push got %0d exp 1", bus.q_count);
    end
    tick();
    n_checks++;
    if (bus.q_count !== 7'd0 || cur_out() !== c || bus.pru_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop got q=%0d out=%h st=%b exp q=0 out=%h st=0",
               bus.q_count, cur_out(), bus.pru_start, c);
    end
    tick();
    n_checks++;
    if (bus.pru_start !== 1'b1) begin
      n_fail++; $display("FAIL single_start_latency got %b exp 1", bus.pru_start);
    end
    hi = 0;
    while (bus.pru_start === 1'b1 && hi < 200) begin
      hi++;
      tick();
    end
    n_checks++;
    if (hi !== pru_lat + 1 || bus.pru_done !== 1'b1) begin
      n_fail++;
      $display("FAIL single_start_width got %0d done=%b exp %0d done=1",
               hi, bus.pru_done, pru_lat + 1);
    end
    wait_drain();
    n_checks++;
    if (issued.size() !== 1 || cur_out() !== c || unstable !== 0) begin
      n_fail++;
      $display("FAIL single_issue got n=%0d out=%h unst=%0d exp n=1 out=%h unst=0",
               issued.size(), cur_out(), unstable, c);
    end
    issued.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    cmd_t c;
    int n;
    for (int r = 0; r < 4; r++) begin
      pru_lat = $urandom_range(2, 8);
      n = (r == 0) ? 3 : $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        c = rand_cmd();
        exp_q.push_back(c);
        push_cmd(c);
        repeat ($urandom_range(0, 3)) tick();
      end
      wait_issued(n);
      wait_drain();
      n_checks++;
      if (issued.size() !== exp_q.size()) begin
        n_fail++;
        $display("FAIL b2b_count round %0d got %0d exp %0d",
                 r, issued.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < issued.size(); i++) begin
        n_checks++;
        if (issued[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL b2b_order r%0d i%0d got %h exp %h",
                   r, i, issued[i], exp_q[i]);
        end
      end
      n_checks++;
      if (start_while_done !== 0 || unstable !== 0) begin
        n_fail++;
        $display("FAIL b2b_handshake got swd=%0d unst=%0d exp 0 0",
                 start_while_done, unstable);
      end
      issued.delete();
      exp_q.delete();
    end
  endtask

  task automatic test_overflow();
    cmd_t c;
    logic [31:0] st;
    pru_lat = 5;
    pru_hold = 1'b1;
    c = rand_cmd();
    exp_q.push_back(c);
    push_cmd(c);
    wait_issued(1);
    for (int i = 0; i < DEPTH + 1; i++) begin
      c = rand_cmd();
      if (i < DEPTH) exp_q.push_back(c);
      push_cmd(c);
    end
    n_checks++;
    if (bus.q_count !== 7'(DEPTH)) begin
      n_fail++; $display("FAIL ovf_qcount got %0d exp %0d", bus.q_count, DEPTH);
    end
    read_status(st);
    n_checks++;
    if ((st & NO15) !== (32'h0000_6800 | 32'(DEPTH))) begin
      n_fail++;
      $display("FAIL ovf_status got %h exp %h", st & NO15,
               32'h0000_6800 | 32'(DEPTH));
    end
    write_status();
    read_status(st);
    n_checks++;
    if ((st & NO15) !== (32'h0000_2800 | 32'(DEPTH))) begin
      n_fail++;
      $display("FAIL ovf_clear got %h exp %h", st & NO15,
               32'h0000_2800 | 32'(DEPTH));
    end
    pru_hold = 1'b0;
    wait_issued(DEPTH + 1);
    wait_drain();
    n_checks++;
    if (issued.size() !== DEPTH + 1) begin
      n_fail++;
      $display("FAIL ovf_issue_count got %0d exp %0d", issued.size(), DEPTH + 1);
    end
    for (int i = 0; i < exp_q.size() && i < issued.size(); i++) begin
      n_checks++;
      if (issued[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ovf_order i%0d got %h exp %h", i, issued[i], exp_q[i]);
      end
    end
    issued.delete();
    exp_q.delete();
  endtask

  task automatic test_push_at_pop();
    cmd_t c, x;
    logic [31:0] st;
    int k;
    pru_lat = 3;
    pru_hold = 1'b1;
    c = rand_cmd();
    exp_q.push_back(c);
    push_cmd(c);
    wait_issued(1);
    for (int i = 0; i < DEPTH; i++) begin
      c = rand_cmd();
      exp_q.push_back(c);
      push_cmd(c);
    end
    x = rand_cmd();
    write_lo(x);
    n_checks++;
    if (bus.q_count !== 7'(DEPTH)) begin
      n_fail++; $display("FAIL pap_full got %0d exp %0d", bus.q_count, DEPTH);
    end
    pru_hold = 1'b0;
    k = 0;
    while (bus.pru_start === 1'b1 && k < 200) begin
      k++;
      tick();
    end
    // start fell; done drops next edge, IDLE the edge after, pop the one after.
    tick();
    tick();
    exp_q.push_back(x);
    push_hi(x);
    n_checks++;
    if (bus.q_count !== 7'(DEPTH)) begin
      n_fail++; $display("FAIL pap_qcount got %0d exp %0d", bus.q_count, DEPTH);
    end
    read_status(st);
    n_checks++;
    if (st[14] !== 1'b0) begin
      n_fail++; $display("FAIL pap_ovf got %b exp 0", st[14]);
    end
    wait_issued(DEPTH + 2);
    wait_drain();
    n_checks++;
    if (issued.size() !== DEPTH + 2) begin
      n_fail++;
      $display("FAIL pap_issue_count got %0d exp %0d", issued.size(), DEPTH + 2);
    end
    for (int i = 0; i < exp_q.size() && i < issued.size(); i++) begin
      n_checks++;
      if (issued[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL pap_order i%0d got %h exp %h", i, issued[i], exp_q[i]);
      end
    end
    issued.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    cmd_t c;
    logic [31:0] st;
    pru_lat = 4;
    pru_hold = 1'b1;
    push_cmd(rand_cmd());
    wait_issued(1);
    for (int i = 0; i < 4; i++) push_cmd(rand_cmd());
    n_checks++;
    if (bus.q_count !== 7'd4 || bus.pru_start !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_setup got q=%0d st=%b exp q=4 st=1",
               bus.q_count, bus.pru_start);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.pru_start !== 1'b0 || bus.q_count !== 7'd0 || cur_out() !== 42'd0) begin
      n_fail++;
      $display("FAIL rmid_clear got st=%b q=%0d out=%h exp 0 0 0",
               bus.pru_start, bus.q_count, cur_out());
    end
    tick();
    rst = 1'b0;
    pru_hold = 1'b0;
    issued.delete();
    exp_q.delete();
    repeat (60) tick();
    n_checks++;
    if (issued.size() !== 0 || bus.pru_start !== 1'b0 || bus.q_count !== 7'd0) begin
      n_fail++;
      $display("FAIL rmid_quiet got n=%0d st=%b q=%0d exp 0 0 0",
               issued.size(), bus.pru_start, bus.q_count);
    end
    read_status(st);
    n_checks++;
    if (st !== 32'h0000_1000) begin
      n_fail++; $display("FAIL rmid_status got %h exp 00001000", st);
    end
    c = rand_cmd();
    exp_q.push_back(c);
    push_cmd(c);
    wait_issued(1);
    wait_drain();
    n_checks++;
    if (issued.size() !== 1 || issued[0] !== c) begin
      n_fail++;
      $display("FAIL rmid_after got n=%0d exp 1 cmd %h", issued.size(), c);
    end
    issued.delete();
    exp_q.delete();
  endtask

`ifdef PRU_SEQ_IRQ_EN
  task automatic test_irq();
    cmd_t c;
    logic [31:0] st;
    int k;
    write_status();
    pru_lat = 4;
    pru_hold = 1'b0;
    for (int i = 0; i < 2; i++) begin
      c = rand_cmd();
      exp_q.push_back(c);
      push_cmd(c);
    end
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_early got %b exp 0", bus.irq);
    end
    wait_issued(2);
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_mid got %b exp 0", bus.irq);
    end
    k = 0;
    while (bus.irq !== 1'b1 && k < 200) begin
      k++;
      tick();
    end
    n_checks++;
    if (bus.irq !== 1'b1 || bus.pru_done !== 1'b0 || bus.pru_start !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_drain got irq=%b done=%b st=%b exp 1 0 0",
               bus.irq, bus.pru_done, bus.pru_start);
    end
    read_status(st);
    n_checks++;
    if (st[15] !== 1'b1) begin
      n_fail++; $display("FAIL irq_status got %b exp 1", st[15]);
    end
    write_status();
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_clear got %b exp 0", bus.irq);
    end
    n_checks++;
    if (issued.size() !== 2 || issued[0] !== exp_q[0] || issued[1] !== exp_q[1]) begin
      n_fail++; $display("FAIL irq_order got n=%0d exp 2", issued.size());
    end
    issued.delete();
    exp_q.delete();
  endtask
`endif

  initial begin
    #3000000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_at_pop();
    test_reset_mid();
`ifdef PRU_SEQ_IRQ_EN
    test_irq();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
